red_pitaya_divider_sat: RTL and testbench
=========================================

# red_pitaya_divider_sat

Sequential signed fixed-point divider with rounding and saturation; the inverse operation of the saturating product used in the PID/IQ datapath. It computes quotient = (dividend · 2^SHIFT) / divisor, rounds, and clamps to BITS_OUT with an overflow flag. It serves normalisation and gain-correction paths where one result per few tens of cycles suffices. It is iterative (one quotient bit per clock), so no DSP slices are used.

## Interface
- BITS_IN1, default 14: dividend width, signed.
- BITS_IN2, default 14: divisor width, signed.
- BITS_OUT, default 14: quotient width, signed.
- SHIFT, default 8: fractional bits added to the dividend (left shift before division).
- Derived QBITS = BITS_IN1+SHIFT+1 with rounding, BITS_IN1+SHIFT without.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  request; accepted only in IDLE.
- dividend_i  in  BITS_IN1  signed; latched on acceptance.
- divisor_i  in  BITS_IN2  signed; latched on acceptance.
- busy_o  out  1  high while a division is in progress (DIV, FIN).
- valid_o  out  1  one-cycle pulse: quotient_o/overflow_o updated.
- quotient_o  out  BITS_OUT  signed result; held until next valid_o.
- overflow_o  out  1  saturation or divide-by-zero occurred; held with quotient_o.

## Operation
- States: IDLE, DIV, FIN. Reset → IDLE.
- IDLE: on start_i=1, latch operands; store result sign = sign(dividend) XOR sign(divisor); store magnitudes |dividend| (BITS_IN1 bits unsigned, so -2^(BITS_IN1-1) is exact) and |divisor|; clear remainder; load numerator = |dividend|·2^(QBITS-BITS_IN1); counter = QBITS-1; go DIV.
- DIV: restoring division, MSB first: remainder = {remainder, next numerator bit}; if remainder ≥ |divisor| subtract and shift in 1, else shift in 0. Counter decrements; after QBITS iterations go FIN.
- FIN: with rounding, magnitude M = (Q >> 1) + Q[0] (round half away from zero); without rounding, M = Q (truncation toward zero). Width of M is QBITS bits; no intermediate truncation.
- Saturation: positive sign and M > 2^(BITS_OUT-1)-1 → quotient = 2^(BITS_OUT-1)-1, overflow=1. Negative sign and M > 2^(BITS_OUT-1) → quotient = -2^(BITS_OUT-1), overflow=1. Otherwise quotient = ±M, overflow=0. Negative result with M=0 gives 0.
- Divide by zero (divisor=0): iteration runs normally, result forced: dividend ≥ 0 → max positive, dividend < 0 → min negative, overflow=1. 0/0 → max positive, overflow=1.
- FIN registers quotient_o/overflow_o, pulses valid_o, returns to IDLE.

## Timing
- Reset values: busy_o=0, valid_o=0, quotient_o=0, overflow_o=0, state IDLE.
- start_i sampled at edge E0. busy_o high from E0 to E(QBITS+1). Outputs and valid_o=1 appear after edge E(QBITS+1). Fixed latency QBITS+1 edges, independent of operand values and divide-by-zero (defaults: 24 edges rounded, 23 truncated).
- valid_o is high exactly one cycle, coinciding with IDLE. A start_i in that cycle is accepted (back-to-back throughput one result per QBITS+1 cycles).
- start_i while busy_o=1 is ignored; operand changes during busy have no effect.
- rstn_i low at any time aborts immediately: all outputs to reset values, no valid_o for the aborted operation.

## Configuration
- DIVIDER_SAT_ROUND_EN defined: guard bit computed, round half away from zero, QBITS = BITS_IN1+SHIFT+1.
- Not defined: truncation toward zero, QBITS = BITS_IN1+SHIFT, latency one cycle shorter; saturation and divide-by-zero rules unchanged.

## Test plan
- 100 / 4, defaults, rounding → quotient 6400, overflow 0, valid_o exactly 24 edges after start, busy_o low in valid cycle.
- 3 / 512 → 2 with DIVIDER_SAT_ROUND_EN, 1 without; -3 / 512 → -2 / -1; -10 / 3 → -853 both builds.
- 100 / 2 → 8191, overflow 1; -100 / 2 → -8192, overflow 1; -8192 / -1 → 8191, overflow 1; -32 / 1 → -8192, overflow 0 (exact min, no flag).
- Divide by zero: 5/0 → 8191 ov 1; -5/0 → -8192 ov 1; 0/0 → 8191 ov 1; latency still 24.
- start_i held high with changing operands: only first accepted, second start in valid cycle accepted back-to-back, results match latched operands.
- rstn_i low at edge 10 of a division → outputs zero, no valid_o; new start after release gives correct result.

Source files
------------

// File: rtl/red_pitaya_divider_sat.sv
// Sequential signed fixed-point divider: quotient = (dividend * 2^SHIFT) / divisor, one quotient bit per clock.
// Optional rounding (half away from zero) is enabled by defining DIVIDER_SAT_ROUND_EN; truncation otherwise.
module red_pitaya_divider_sat #(
   parameter int BITS_IN1 = 14,
   parameter int BITS_IN2 = 14,
   parameter int BITS_OUT = 14,
   parameter int SHIFT    = 8
) (
   input  logic                       clk_i,
   input  logic                       rstn_i,
   input  logic                       start_i,
   input  logic signed [BITS_IN1-1:0] dividend_i,
   input  logic signed [BITS_IN2-1:0] divisor_i,
   output logic                       busy_o,
   output logic                       valid_o,
   output logic signed [BITS_OUT-1:0] quotient_o,
   output logic                       overflow_o
);

`ifdef DIVIDER_SAT_ROUND_EN
   localparam int QBITS = BITS_IN1 + SHIFT + 1;
`else
   localparam int QBITS = BITS_IN1 + SHIFT;
`endif
   localparam int CW = $clog2(QBITS);

   localparam logic [QBITS-1:0]    LIM_MAG = {{(QBITS-1){1'b0}}, 1'b1} << (BITS_OUT-1);
   localparam logic [BITS_OUT-1:0] MAX_POS = {1'b0, {(BITS_OUT-1){1'b1}}};
   localparam logic [BITS_OUT-1:0] MIN_NEG = {1'b1, {(BITS_OUT-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, DIV, FIN} state_t;

   state_t              state;
   logic [CW-1:0]       cnt;
   logic [QBITS-1:0]    numer;
   logic [QBITS-1:0]    q;
   logic [BITS_IN2-1:0] rem;
   logic [BITS_IN2-1:0] mag_b;
   logic                res_neg;
   logic                a_neg;
   logic                b_zero;

   logic [BITS_IN1-1:0] abs_a;
   logic [BITS_IN2-1:0] abs_b;
   logic [BITS_IN2:0]   trial;
   logic [BITS_IN2-1:0] diff;
   logic                ge;
   logic [BITS_IN2-1:0] rem_next;
   logic [QBITS-1:0]    mag;
   logic [BITS_OUT-1:0] sat_q;
   logic                sat_ov;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      abs_a = dividend_i[BITS_IN1-1] ? (~dividend_i + 1'b1) : dividend_i;
      abs_b = divisor_i[BITS_IN2-1]  ? (~divisor_i + 1'b1)  : divisor_i;

      // Remainder stays below |divisor|, so the low BITS_IN2 bits of the difference are exact.
      trial    = {rem, numer[QBITS-1]};
      ge       = trial >= {1'b0, mag_b};
      diff     = trial[BITS_IN2-1:0] - mag_b;
      rem_next = ge ? diff : trial[BITS_IN2-1:0];
   end

   always_comb begin
`ifdef DIVIDER_SAT_ROUND_EN
      mag = {1'b0, q[QBITS-1:1]} + {{(QBITS-1){1'b0}}, q[0]};
`else
      mag = q;
`endif
      sat_q  = '0;
      sat_ov = 1'b0;
      if (b_zero) begin
         sat_q  = a_neg ? MIN_NEG : MAX_POS;
         sat_ov = 1'b1;
      end else if (!res_neg) begin
         if (mag >= LIM_MAG) begin
            sat_q  = MAX_POS;
            sat_ov = 1'b1;
         end else begin
            sat_q = mag[BITS_OUT-1:0];
         end
      end else begin
         if (mag > LIM_MAG) begin
            sat_q  = MIN_NEG;
            sat_ov = 1'b1;
         end else begin
            sat_q = ~mag[BITS_OUT-1:0] + 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state      <= IDLE;
         cnt        <= '0;
         numer      <= '0;
         q          <= '0;
         rem        <= '0;
         mag_b      <= '0;
         res_neg    <= 1'b0;
         a_neg      <= 1'b0;
         b_zero     <= 1'b0;
         busy_o     <= 1'b0;
         valid_o    <= 1'b0;
         quotient_o <= '0;
         overflow_o <= 1'b0;
      end else begin
         valid_o <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  res_neg <= dividend_i[BITS_IN1-1] ^ divisor_i[BITS_IN2-1];
                  a_neg   <= dividend_i[BITS_IN1-1];
                  b_zero  <= (divisor_i == '0);
                  mag_b   <= abs_b;
                  rem     <= '0;
                  q       <= '0;
                  numer   <= {abs_a, {(QBITS-BITS_IN1){1'b0}}};
                  cnt     <= CW'(QBITS-1);
                  busy_o  <= 1'b1;
                  state   <= DIV;
               end
            end
            DIV: begin
               rem   <= rem_next;
               q     <= {q[QBITS-2:0], ge};
               numer <= {numer[QBITS-2:0], 1'b0};
               cnt   <= cnt - 1'b1;
               if (cnt == '0) state <= FIN;
            end
            FIN: begin
               quotient_o <= sat_q;
               overflow_o <= sat_ov;
               valid_o    <= 1'b1;
               busy_o     <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_red_pitaya_divider_sat.sv
// Directed bench for red_pitaya_divider_sat: results, saturation, divide-by-zero, latency, back-to-back, reset abort.
// Expectations follow DIVIDER_SAT_ROUND_EN when it is defined for the build.
module tb_red_pitaya_divider_sat;

`ifdef DIVIDER_SAT_ROUND_EN
   localparam int LAT   = 24;
   localparam int R3    = 2;
`else
   localparam int LAT   = 23;
   localparam int R3    = 1;
`endif

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic signed [13:0] dividend = '0;
   logic signed [13:0] divisor = '0;
   logic               busy;
   logic               valid;
   logic signed [13:0] quotient;
   logic               overflow;

   int checks = 0;
   int failures = 0;

   red_pitaya_divider_sat dut (
      .clk_i      (clk),
      .rstn_i     (rst_n),
      .start_i    (start),
      .dividend_i (dividend),
      .divisor_i  (divisor),
      .busy_o     (busy),
      .valid_o    (valid),
      .quotient_o (quotient),
      .overflow_o (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Waits for valid_o after the start edge already taken; returns edges counted (bounded).
   task automatic wait_valid(output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!valid && n < 200);
   endtask

   task automatic run_div(input string tag, input int a, input int b, input int exp_q, input int exp_ov);
      int n;
      dividend = 14'(a);
      divisor  = 14'(b);
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_valid(n);
      check({tag, "_lat"}, n, LAT);
      check({tag, "_q"}, int'(quotient), exp_q);
      check({tag, "_ov"}, int'(overflow), exp_ov);
      check({tag, "_busy"}, int'(busy), 0);
   endtask

   initial begin
      int n;
      int vcount;

      #3;
      check("rst_busy", int'(busy), 0);
      check("rst_valid", int'(valid), 0);
      check("rst_q", int'(quotient), 0);
      check("rst_ov", int'(overflow), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_div("d100_4", 100, 4, 6400, 0);
      run_div("d3_512", 3, 512, R3, 0);
      run_div("dm3_512", -3, 512, -R3, 0);
      run_div("dm10_3", -10, 3, -853, 0);
      run_div("d0_5", 0, 5, 0, 0);
      run_div("d100_2", 100, 2, 8191, 1);
      run_div("dm100_2", -100, 2, -8192, 1);
      run_div("dm8192_m1", -8192, -1, 8191, 1);
      run_div("dm32_1", -32, 1, -8192, 0);
      run_div("d5_0", 5, 0, 8191, 1);
      run_div("dm5_0", -5, 0, -8192, 1);
      run_div("d0_0", 0, 0, 8191, 1);

      // start held high while operands change: only the first request counts until valid_o
      dividend = 14'sd100;
      divisor  = 14'sd4;
      start    = 1'b1;
      @(posedge clk);
      #1;
      n = 0;
      do begin
         dividend = 14'(n * 37 - 500);
         divisor  = 14'(n + 1);
         @(posedge clk);
         #1;
         n++;
         if (n == 5) check("hold_busy", int'(busy), 1);
      end while (!valid && n < 200);
      check("hold_lat", n, LAT);
      check("hold_q", int'(quotient), 6400);
      check("hold_ov", int'(overflow), 0);
      dividend = -14'sd10;
      divisor  = 14'sd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("b2b_busy", int'(busy), 1);
      wait_valid(n);
      check("b2b_lat", n, LAT);
      check("b2b_q", int'(quotient), -853);
      check("b2b_ov", int'(overflow), 0);

      // reset mid-division aborts the operation
      dividend = 14'sd100;
      divisor  = 14'sd2;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_busy", int'(busy), 0);
      check("abort_q", int'(quotient), 0);
      check("abort_ov", int'(overflow), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      vcount = 0;
      repeat (LAT + 5) begin
         @(posedge clk);
         #1;
         if (valid) vcount++;
      end
      check("abort_novalid", vcount, 0);
      check("abort_q_hold", int'(quotient), 0);
      run_div("post_rst", -3, 512, -R3, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
